// File: rtl/esp_dma_pkg.sv
// Shared types and helpers for the ESP DMA burst reader.
package esp_dma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StData,
        StFin
    } dma_state_e;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [2:0] SIZE_DWORD = 3'b011;

    // Wide arguments so any LEN_W up to 64 can use it; callers truncate the result.
    function automatic logic [63:0] min_len(input logic [63:0] remaining,
                                            input logic [63:0] max_burst);
        return (remaining < max_burst) ? remaining : max_burst;
    endfunction

endpackage

// File: rtl/esp_dma_skid_fifo.sv
// Small power-of-two FIFO used as the output skid buffer of the DMA burst reader.
module esp_dma_skid_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/esp_dma_burst_reader.sv
// ESP DMA read engine: splits a logical read into bounded bursts and streams the
// returned beats downstream, optionally as WORD_W-wide words low word first.
module esp_dma_burst_reader
    import esp_dma_pkg::*;
#(
    parameter int unsigned DMA_WIDTH  = 64,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned MAX_BURST  = 128,
    parameter int unsigned LEN_W      = 32,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 split_mode,
    input  logic [LEN_W-1:0]     base_index,
    input  logic [LEN_W-1:0]     total_beats,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     beats_rcvd,
    output logic                 dma_read_ctrl_valid,
    input  logic                 dma_read_ctrl_ready,
    output logic [LEN_W-1:0]     dma_read_ctrl_data_index,
    output logic [LEN_W-1:0]     dma_read_ctrl_data_length,
    output logic [2:0]           dma_read_ctrl_data_size,
    output logic [5:0]           dma_read_ctrl_data_user,
    input  logic                 dma_read_chnl_valid,
    output logic                 dma_read_chnl_ready,
    input  logic [DMA_WIDTH-1:0] dma_read_chnl_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DMA_WIDTH-1:0] out_data,
    output logic                 out_last
);

    localparam int unsigned NWORDS = DMA_WIDTH / WORD_W;
    localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    dma_state_e          r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_split;
    logic [LEN_W-1:0]    r_remaining;
    logic [LEN_W-1:0]    r_next_index;
    logic [LEN_W-1:0]    r_burst_cnt;
    logic [LEN_W-1:0]    r_beats_rcvd;
    logic                r_ctrl_valid;
    logic [LEN_W-1:0]    r_index;
    logic [LEN_W-1:0]    r_length;
    logic [WIDX_W-1:0]   r_word_idx;

    logic                w_chnl_ready;
    logic                w_chnl_hs;
    logic                w_beat_last;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_last_word;
    logic [DMA_WIDTH:0]  w_head;
    logic [DMA_WIDTH-1:0] w_head_data;
    logic                w_head_last;
    logic [LEN_W-1:0]    w_len_start;
    logic [LEN_W-1:0]    w_len_rem;

    assign w_len_start = LEN_W'(min_len(64'(total_beats), 64'(MAX_BURST)));
    assign w_len_rem   = LEN_W'(min_len(64'(r_remaining), 64'(MAX_BURST)));

    assign w_chnl_ready = (r_state == StData) && !w_full && (r_burst_cnt != '0);
    assign w_chnl_hs    = w_chnl_ready && dma_read_chnl_valid;
    // r_remaining already excludes the current burst, so this is the transfer's last beat.
    assign w_beat_last  = (r_remaining == '0) && (r_burst_cnt == LEN_W'(1));

    esp_dma_skid_fifo #(
        .WIDTH (DMA_WIDTH + 1),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_chnl_hs),
        .i_data  ({w_beat_last, dma_read_chnl_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_split      <= 1'b0;
            r_remaining  <= '0;
            r_next_index <= '0;
            r_burst_cnt  <= '0;
            r_beats_rcvd <= '0;
            r_ctrl_valid <= 1'b0;
            r_index      <= '0;
            r_length     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_busy       <= 1'b1;
                        r_split      <= split_mode;
                        r_beats_rcvd <= '0;
                        r_remaining  <= total_beats;
                        r_next_index <= base_index;
                        if (total_beats == '0) begin
                            r_state <= StFin;
                        end else begin
                            r_state      <= StReq;
                            r_ctrl_valid <= 1'b1;
                            r_index      <= base_index;
                            r_length     <= w_len_start;
                        end
                    end
                end
                StReq: begin
                    if (dma_read_ctrl_ready) begin
                        r_ctrl_valid <= 1'b0;
                        r_burst_cnt  <= r_length;
                        r_next_index <= r_next_index + r_length;
                        r_remaining  <= r_remaining - r_length;
                        r_state      <= StData;
                    end
                end
                StData: begin
                    if (w_chnl_hs) begin
                        r_burst_cnt  <= r_burst_cnt - 1'b1;
                        r_beats_rcvd <= r_beats_rcvd + 1'b1;
                    end
                    if (r_burst_cnt == '0) begin
                        if (r_remaining != '0) begin
                            r_state      <= StReq;
                            r_ctrl_valid <= 1'b1;
                            r_index      <= r_next_index;
                            r_length     <= w_len_rem;
                        end else if (w_empty) begin
                            r_state <= StFin;
                        end
                    end
                end
                StFin: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Word splitter: walks the FIFO head word by word, popping after the top word.
    assign w_head_data = w_head[DMA_WIDTH-1:0];
    assign w_head_last = w_head[DMA_WIDTH];
    assign w_last_word = !r_split || (r_word_idx == WIDX_W'(NWORDS - 1));
    assign w_pop       = !w_empty && out_ready && w_last_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_idx <= '0;
        end else if (r_split && !w_empty && out_ready) begin
            r_word_idx <= w_last_word ? '0 : r_word_idx + 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        if (!w_empty) begin
            if (r_split) begin
                out_data[WORD_W-1:0] = w_head_data[int'(r_word_idx) * WORD_W +: WORD_W];
            end else begin
                out_data = w_head_data;
            end
        end
    end

    assign out_valid = !w_empty;
    assign out_last  = !w_empty && w_head_last && w_last_word;

    assign busy                      = r_busy;
    assign done                      = r_done;
    assign beats_rcvd                = r_beats_rcvd;
    assign dma_read_ctrl_valid       = r_ctrl_valid;
    assign dma_read_ctrl_data_index  = r_index;
    assign dma_read_ctrl_data_length = r_length;
    assign dma_read_ctrl_data_size   = (DMA_WIDTH == 64) ? SIZE_DWORD : SIZE_WORD;
    assign dma_read_ctrl_data_user   = '0;
    assign dma_read_chnl_ready       = w_chnl_ready;

endmodule
